drive_sequencer: RTL and testbench
==================================

# drive_sequencer

Parametrised motor-drive sequencer for the line-following robot. It sits between the path/junction decision logic and the dual H-bridge. It turns the 4-bit steering command and the junction direction into H-bridge direction bits and two PWM enables. Compared with the previous drive block it adds internal PWM generation with duty slew limiting, collision debounce with resume-where-interrupted, and parameterised manoeuvre lengths.

## Interface
- PWM_W, 8: duty and PWM counter width.
- CNT_W, 27: junction counter width.
- JNC_STRAIGHT_CYC, 5_000_000: straight-through manoeuvre length.
- JNC_TURN_CYC, 75_000_000: left/right pivot length.
- JNC_BACK_CYC, 50_000_000: back manoeuvre length.
- COL_CLEAR_CYC, 1_000_000: consecutive clear cycles required before resuming.
- RAMP_DIV, 1000: cycles per duty slew step; 0 disables slewing.
- RAMP_STEP, 4: duty increment per slew step.
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- col_n, input, 1: low = obstacle present.
- dir_control, input, 4: [3:2] turn (PROCEED/TURN_LEFT/TURN_RIGHT/STOP), [1:0] degree (NONE/VEER/HARD/PIVOT).
- td_dir, input, 3: junction decision (STOP/STRAIGHT/LEFT/RIGHT/BACK).
- duty_full, duty_veer, duty_hard, duty_ninety, duty_ninety_fast, input, PWM_W each: speed set-points.
- hb_in, output, 4: H-bridge IN4..IN1.
- hb_en_a, hb_en_b, output, 1 each: PWM enables, A = right motor, B = left motor.
- drive_state, output, 2: current FSM state.
- drive_rev, output, 1: 1 = reversed orientation.
- jnc_done, output, 1: one-cycle pulse when a junction manoeuvre completes.

## Operation
- Reset: drive_state=DRIVE, drive_rev=0, hb_in=0000, hb_en_a/b=0, jnc_done=0; all duties and counters 0.
- Patterns: STRAIGHT=0101, LEFT=0110, RIGHT=1001, STOP=0000. When drive_rev=1, every non-STOP pattern is bitwise inverted.
- The selection below sets target duty (A,B) and pattern.
- DRIVE state:
  - LEFT VEER: (veer, full), STRAIGHT.
  - LEFT HARD: (veer, hard), LEFT.
  - LEFT PIVOT: (ninety, ninety_fast), LEFT.
  - RIGHT commands mirror LEFT, with A and B swapped and the RIGHT pattern.
  - PROCEED NONE: (full, full), STRAIGHT.
  - Any other PROCEED or turn code: hold the previous targets.
  - STOP: (0,0), STOP, then go to JUNCTION with the counter cleared.
- JUNCTION state (counter increments every cycle):
  - td_dir STOP: (0,0), STOP; stay.
  - STRAIGHT: (full, full), STRAIGHT while cnt<JNC_STRAIGHT_CYC. Then set drive_rev=0 and go to DRIVE.
  - LEFT: (ninety, ninety_fast), LEFT while cnt<JNC_TURN_CYC. After that, creep at (full, full) STRAIGHT while dir_control[3:2]==STOP. Otherwise go to DRIVE.
  - RIGHT: mirror of LEFT.
  - BACK: (full, full), STRAIGHT while cnt<JNC_BACK_CYC. Then toggle drive_rev and go to DRIVE.
  - Any other td_dir code: go to DRIVE immediately with drive_rev=0.
  - Every exit to DRIVE clears the counter and pulses jnc_done.
- Collision:
  - col_n=0 in DRIVE or JUNCTION: go to COLLISION and latch the return state. The junction counter freezes.
  - COLLISION: targets (0,0); go to CLEAR when col_n=1.
  - CLEAR: targets (0,0); counts consecutive col_n=1 cycles. col_n=0 returns to COLLISION and zeroes the count. Reaching COL_CLEAR_CYC returns to the latched state, and the junction count resumes.
  - Collision takes priority over every other transition in the same cycle.
- Slew:
  - Duty moves toward target by RAMP_STEP every RAMP_DIV cycles, saturating at the target.
  - A zero target, or a decrease, loads immediately.
  - RAMP_DIV=0 loads every target immediately.
- PWM: pwm_cnt is free-running, PWM_W bits, and wraps. hb_en_x = (pwm_cnt < duty_x), so all-ones duty gives (2^PWM_W−1)/2^PWM_W.

## Timing
- hb_in, targets, and (with RAMP_DIV=0) duty update on the edge after the inputs are sampled. hb_en follows one edge later.
- State transitions take effect on the next edge. The junction phase boundary is checked against the pre-increment count.
- Reset asserted mid-manoeuvre or mid-collision returns all state to reset values on the next edge.

## Structure
- Package drive_pkg holds:
  - state encodings: DRIVE=00, COLLISION=01, JUNCTION=10, CLEAR=11;
  - dir_control codes: turn PROCEED=00, LEFT=01, RIGHT=10, STOP=11; degree NONE=00, VEER=01, HARD=10, PIVOT=11;
  - td_dir codes: STOP=0, STRAIGHT=1, LEFT=2, RIGHT=3, BACK=4;
  - the four H-bridge patterns.
- One sub-module, pwm_slew_channel, holds target, slew, and compare logic. It is instantiated twice, for A and B.

## Test plan
- Reset, then dir_control=0000 with duty_full=200, RAMP_DIV=0: hb_in=0101 after 1 edge; hb_en_a high for 200 of every 256 cycles.
- dir_control=1100, td_dir=LEFT, JNC_TURN_CYC=100: hb_in=0110 for 100 cycles, then creep while STOP is held; on dir 0000, return to DRIVE with one jnc_done pulse.
- td_dir=BACK, JNC_BACK_CYC=50: after 50 cycles drive_rev=1 and straight hb_in=1010.
- col_n low at junction cnt=40, bouncing once during CLEAR, COL_CLEAR_CYC=10: enables stay 0 throughout; resume at cnt=40; total turn time is unchanged.
- RAMP_DIV=4, RAMP_STEP=16, duty_full 0→128: duty reaches 128 after 32 cycles. A stop command drops duty to 0 on the next edge.

Source files
------------

// File: rtl/drive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drive_pkg
// Description : Shared encodings for the drive sequencer: FSM states,
//               steering/junction command codes and H-bridge patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package drive_pkg;

    localparam logic [1:0] c_ST_DRIVE     = 2'b00;
    localparam logic [1:0] c_ST_COLLISION = 2'b01;
    localparam logic [1:0] c_ST_JUNCTION  = 2'b10;
    localparam logic [1:0] c_ST_CLEAR     = 2'b11;

    localparam logic [1:0] c_TURN_PROCEED = 2'b00;
    localparam logic [1:0] c_TURN_LEFT    = 2'b01;
    localparam logic [1:0] c_TURN_RIGHT   = 2'b10;
    localparam logic [1:0] c_TURN_STOP    = 2'b11;

    localparam logic [1:0] c_DEG_NONE     = 2'b00;
    localparam logic [1:0] c_DEG_VEER     = 2'b01;
    localparam logic [1:0] c_DEG_HARD     = 2'b10;
    localparam logic [1:0] c_DEG_PIVOT    = 2'b11;

    localparam logic [2:0] c_TD_STOP      = 3'd0;
    localparam logic [2:0] c_TD_STRAIGHT  = 3'd1;
    localparam logic [2:0] c_TD_LEFT      = 3'd2;
    localparam logic [2:0] c_TD_RIGHT     = 3'd3;
    localparam logic [2:0] c_TD_BACK      = 3'd4;

    localparam logic [3:0] c_HB_STRAIGHT  = 4'b0101;
    localparam logic [3:0] c_HB_LEFT      = 4'b0110;
    localparam logic [3:0] c_HB_RIGHT     = 4'b1001;
    localparam logic [3:0] c_HB_STOP      = 4'b0000;

    // Reversed orientation swaps the role of both bridges; STOP stays STOP.
    function automatic logic [3:0] orient(input logic [3:0] pat, input logic rev);
        return (rev && (pat != c_HB_STOP)) ? ~pat : pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_slew_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_slew_channel
// Description : One motor channel: target hold, duty slew limiter and PWM
//               compare against a shared free-running counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_slew_channel #(
    parameter int PWM_W     = 8,
    parameter int RAMP_DIV  = 1000,
    parameter int RAMP_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] i_pwm_cnt,
    input  logic             i_tgt_load,
    input  logic [PWM_W-1:0] i_tgt,
    input  logic             i_force_zero,
    output logic             o_en
);

    localparam int c_DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PWM_W-1:0] r_tgt;
    logic [PWM_W-1:0] r_duty;
    logic             r_en;
    logic [PWM_W-1:0] w_eff;
    logic [PWM_W:0]   w_sum;
    logic [PWM_W-1:0] w_duty_nxt;
    logic             w_tick;

    // Forced zero leaves the stored target intact so a held command resumes.
    assign w_eff = i_force_zero ? '0 : (i_tgt_load ? i_tgt : r_tgt);
    assign w_sum = {1'b0, r_duty} + (PWM_W+1)'(RAMP_STEP);

    generate
        if (RAMP_DIV == 0) begin : g_no_ramp
            assign w_tick = 1'b0;
        end else begin : g_ramp
            logic [c_DIV_W-1:0] r_div;
            assign w_tick = (r_div == c_DIV_W'(RAMP_DIV - 1));
            always_ff @(posedge clk) begin
                if (rst)         r_div <= '0;
                else if (w_tick) r_div <= '0;
                else             r_div <= r_div + 1'b1;
            end
        end
    endgenerate

    always_comb begin
        w_duty_nxt = r_duty;
        if ((RAMP_DIV == 0) || (w_eff == '0) || (w_eff < r_duty))
            w_duty_nxt = w_eff;
        else if (w_tick)
            w_duty_nxt = (w_sum >= {1'b0, w_eff}) ? w_eff : w_sum[PWM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tgt  <= '0;
            r_duty <= '0;
            r_en   <= 1'b0;
        end else begin
            if (i_tgt_load) r_tgt <= i_tgt;
            r_duty <= w_duty_nxt;
            r_en   <= (i_pwm_cnt < r_duty);
        end
    end

    assign o_en = r_en;

endmodule
`default_nettype wire

// File: rtl/drive_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : drive_sequencer
// Description : Steering/junction sequencer for the dual H-bridge with
//               collision debounce, resume and slew-limited PWM enables.
// Revision    : 1.0 - initial release
// ============================================================================
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int PWM_W            = 8,
    parameter int CNT_W            = 27,
    parameter int JNC_STRAIGHT_CYC = 5_000_000,
    parameter int JNC_TURN_CYC     = 75_000_000,
    parameter int JNC_BACK_CYC     = 50_000_000,
    parameter int COL_CLEAR_CYC    = 1_000_000,
    parameter int RAMP_DIV         = 1000,
    parameter int RAMP_STEP        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             col_n,
    input  logic [3:0]       dir_control,
    input  logic [2:0]       td_dir,
    input  logic [PWM_W-1:0] duty_full,
    input  logic [PWM_W-1:0] duty_veer,
    input  logic [PWM_W-1:0] duty_hard,
    input  logic [PWM_W-1:0] duty_ninety,
    input  logic [PWM_W-1:0] duty_ninety_fast,
    output logic [3:0]       hb_in,
    output logic             hb_en_a,
    output logic             hb_en_b,
    output logic [1:0]       drive_state,
    output logic             drive_rev,
    output logic             jnc_done
);

    localparam int               c_CLR_W     = $clog2(COL_CLEAR_CYC + 1);
    localparam logic [CNT_W-1:0] c_STRAIGHT  = CNT_W'(JNC_STRAIGHT_CYC);
    localparam logic [CNT_W-1:0] c_TURN      = CNT_W'(JNC_TURN_CYC);
    localparam logic [CNT_W-1:0] c_BACK      = CNT_W'(JNC_BACK_CYC);
    localparam logic [c_CLR_W-1:0] c_CLR_LAST = c_CLR_W'(COL_CLEAR_CYC - 1);

    logic [1:0]         r_state, r_ret, w_state_nxt, w_ret_nxt;
    logic               r_rev, w_rev_nxt, r_done, w_done_nxt, w_exit;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [c_CLR_W-1:0] r_clr, w_clr_nxt;
    logic [3:0]         r_hb, w_pat;
    logic               w_pat_load, w_tgt_load, w_zero;
    logic [PWM_W-1:0]   w_tgt_a, w_tgt_b, r_pwm_cnt;
    logic [1:0]         w_turn, w_deg;

    assign w_turn = dir_control[3:2];
    assign w_deg  = dir_control[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_rev_nxt   = r_rev;
        w_cnt_nxt   = r_cnt;
        w_clr_nxt   = r_clr;
        w_done_nxt  = 1'b0;
        w_exit      = 1'b0;
        w_pat_load  = 1'b0;
        w_pat       = c_HB_STOP;
        w_tgt_load  = 1'b0;
        w_tgt_a     = '0;
        w_tgt_b     = '0;
        w_zero      = 1'b0;
        case (r_state)
            c_ST_DRIVE: begin
                w_tgt_load = (w_deg != c_DEG_NONE) || (w_turn == c_TURN_STOP)
                             || (w_turn == c_TURN_PROCEED);
                if (w_turn == c_TURN_PROCEED) w_tgt_load = (w_deg == c_DEG_NONE);
                w_pat_load = w_tgt_load;
                case (w_turn)
                    c_TURN_PROCEED: begin
                        w_tgt_a = duty_full; w_tgt_b = duty_full; w_pat = c_HB_STRAIGHT;
                    end
                    c_TURN_LEFT: begin
                        case (w_deg)
                            c_DEG_VEER:  begin w_tgt_a = duty_veer;   w_tgt_b = duty_full;        w_pat = c_HB_STRAIGHT; end
                            c_DEG_HARD:  begin w_tgt_a = duty_veer;   w_tgt_b = duty_hard;        w_pat = c_HB_LEFT;     end
                            c_DEG_PIVOT: begin w_tgt_a = duty_ninety; w_tgt_b = duty_ninety_fast; w_pat = c_HB_LEFT;     end
                            default: ;
                        endcase
                    end
                    c_TURN_RIGHT: begin
                        case (w_deg)
                            c_DEG_VEER:  begin w_tgt_a = duty_full;        w_tgt_b = duty_veer;   w_pat = c_HB_STRAIGHT; end
                            c_DEG_HARD:  begin w_tgt_a = duty_hard;        w_tgt_b = duty_veer;   w_pat = c_HB_RIGHT;    end
                            c_DEG_PIVOT: begin w_tgt_a = duty_ninety_fast; w_tgt_b = duty_ninety; w_pat = c_HB_RIGHT;    end
                            default: ;
                        endcase
                    end
                    default: begin
                        w_state_nxt = c_ST_JUNCTION;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
            c_ST_JUNCTION: begin
                w_cnt_nxt = r_cnt + 1'b1;
                case (td_dir)
                    c_TD_STOP: begin
                        w_tgt_load = 1'b1; w_pat_load = 1'b1;
                    end
                    c_TD_STRAIGHT, c_TD_BACK: begin
                        if (r_cnt < ((td_dir == c_TD_BACK) ? c_BACK : c_STRAIGHT)) begin
                            w_tgt_load = 1'b1; w_pat_load = 1'b1;
                            w_tgt_a = duty_full; w_tgt_b = duty_full; w_pat = c_HB_STRAIGHT;
                        end else begin
                            w_exit    = 1'b1;
                            w_rev_nxt = (td_dir == c_TD_BACK) ? ~r_rev : 1'b0;
                        end
                    end
                    c_TD_LEFT, c_TD_RIGHT: begin
                        w_tgt_load = 1'b1; w_pat_load = 1'b1;
                        if (r_cnt < c_TURN) begin
                            w_tgt_a = (td_dir == c_TD_LEFT) ? duty_ninety : duty_ninety_fast;
                            w_tgt_b = (td_dir == c_TD_LEFT) ? duty_ninety_fast : duty_ninety;
                            w_pat   = (td_dir == c_TD_LEFT) ? c_HB_LEFT : c_HB_RIGHT;
                        end else if (w_turn == c_TURN_STOP) begin
                            w_tgt_a = duty_full; w_tgt_b = duty_full; w_pat = c_HB_STRAIGHT;
                        end else begin
                            w_tgt_load = 1'b0; w_pat_load = 1'b0; w_exit = 1'b1;
                        end
                    end
                    default: begin
                        w_exit    = 1'b1;
                        w_rev_nxt = 1'b0;
                    end
                endcase
                if (w_exit) begin
                    w_state_nxt = c_ST_DRIVE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            c_ST_COLLISION: begin
                w_zero    = 1'b1;
                w_clr_nxt = '0;
                if (col_n) w_state_nxt = c_ST_CLEAR;
            end
            default: begin
                w_zero = 1'b1;
                if (!col_n) begin
                    w_state_nxt = c_ST_COLLISION;
                    w_clr_nxt   = '0;
                end else if (r_clr == c_CLR_LAST) begin
                    w_state_nxt = r_ret;
                    w_clr_nxt   = '0;
                end else begin
                    w_clr_nxt = r_clr + 1'b1;
                end
            end
        endcase
        // An obstacle pre-empts everything: freeze the manoeuvre where it is.
        if (!col_n && ((r_state == c_ST_DRIVE) || (r_state == c_ST_JUNCTION))) begin
            w_state_nxt = c_ST_COLLISION;
            w_ret_nxt   = r_state;
            w_rev_nxt   = r_rev;
            w_cnt_nxt   = r_cnt;
            w_clr_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_pat_load  = 1'b0;
            w_tgt_load  = 1'b0;
            w_zero      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_DRIVE;
            r_ret     <= c_ST_DRIVE;
            r_rev     <= 1'b0;
            r_cnt     <= '0;
            r_clr     <= '0;
            r_hb      <= c_HB_STOP;
            r_done    <= 1'b0;
            r_pwm_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret     <= w_ret_nxt;
            r_rev     <= w_rev_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clr     <= w_clr_nxt;
            r_done    <= w_done_nxt;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_pat_load) r_hb <= orient(w_pat, r_rev);
        end
    end

    pwm_slew_channel #(.PWM_W(PWM_W), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP)) u_chan_a (
        .clk          (clk),
        .rst          (rst),
        .i_pwm_cnt    (r_pwm_cnt),
        .i_tgt_load   (w_tgt_load),
        .i_tgt        (w_tgt_a),
        .i_force_zero (w_zero),
        .o_en         (hb_en_a)
    );

    pwm_slew_channel #(.PWM_W(PWM_W), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP)) u_chan_b (
        .clk          (clk),
        .rst          (rst),
        .i_pwm_cnt    (r_pwm_cnt),
        .i_tgt_load   (w_tgt_load),
        .i_tgt        (w_tgt_b),
        .i_force_zero (w_zero),
        .o_en         (hb_en_b)
    );

    assign hb_in       = r_hb;
    assign drive_state = r_state;
    assign drive_rev   = r_rev;
    assign jnc_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_drive_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_drive_sequencer
// Description : Scoreboard bench for drive_sequencer (direct-load and slewed
//               instances); expected values are hand-derived per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_drive_sequencer;

    localparam int K_HB = 0, K_ST = 1, K_REV = 2, K_DONE = 3, K_ENA = 4, K_ENB = 5;
    localparam int K_WA = 6, K_WB = 7, K_REN = 8, K_WR = 9;

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, col_n;
    logic [3:0] dir_control, dir_r;
    logic [2:0] td_dir;
    logic [7:0] duty_full, duty_veer, duty_hard, duty_ninety, duty_ninety_fast, duty_full_r;
    logic [3:0] hb_in, hb_in_r;
    logic       hb_en_a, hb_en_b, hb_en_a_r, hb_en_b_r;
    logic [1:0] drive_state, drive_state_r;
    logic       drive_rev, drive_rev_r, jnc_done, jnc_done_r;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   t_rel = 0;
    bit   hist_a[256], hist_b[256], hist_r[256];
    int   sum_a = 0, sum_b = 0, sum_r = 0, hp = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    drive_sequencer #(
        .PWM_W(8), .CNT_W(16), .JNC_STRAIGHT_CYC(20), .JNC_TURN_CYC(100),
        .JNC_BACK_CYC(50), .COL_CLEAR_CYC(10), .RAMP_DIV(0), .RAMP_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .col_n(col_n), .dir_control(dir_control), .td_dir(td_dir),
        .duty_full(duty_full), .duty_veer(duty_veer), .duty_hard(duty_hard),
        .duty_ninety(duty_ninety), .duty_ninety_fast(duty_ninety_fast),
        .hb_in(hb_in), .hb_en_a(hb_en_a), .hb_en_b(hb_en_b),
        .drive_state(drive_state), .drive_rev(drive_rev), .jnc_done(jnc_done)
    );

    drive_sequencer #(
        .PWM_W(8), .CNT_W(16), .JNC_STRAIGHT_CYC(20), .JNC_TURN_CYC(100),
        .JNC_BACK_CYC(50), .COL_CLEAR_CYC(10), .RAMP_DIV(4), .RAMP_STEP(16)
    ) dut_ramp (
        .clk(clk), .rst(rst), .col_n(col_n), .dir_control(dir_r), .td_dir(td_dir),
        .duty_full(duty_full_r), .duty_veer(duty_veer), .duty_hard(duty_hard),
        .duty_ninety(duty_ninety), .duty_ninety_fast(duty_ninety_fast),
        .hb_in(hb_in_r), .hb_en_a(hb_en_a_r), .hb_en_b(hb_en_b_r),
        .drive_state(drive_state_r), .drive_rev(drive_rev_r), .jnc_done(jnc_done_r)
    );

    function automatic int observe(input int k);
        case (k)
            K_HB:    return int'(hb_in);
            K_ST:    return int'(drive_state);
            K_REV:   return int'(drive_rev);
            K_DONE:  return int'(jnc_done);
            K_ENA:   return int'(hb_en_a);
            K_ENB:   return int'(hb_en_b);
            K_WA:    return sum_a;
            K_WB:    return sum_b;
            K_REN:   return int'(hb_en_a_r);
            K_WR:    return sum_r;
            default: return -1;
        endcase
    endfunction

    // Monitor: rolling 256-cycle enable counts, then retire due expectations.
    always @(negedge clk) begin
        sum_a = sum_a + int'(hb_en_a)   - int'(hist_a[hp]);
        sum_b = sum_b + int'(hb_en_b)   - int'(hist_b[hp]);
        sum_r = sum_r + int'(hb_en_a_r) - int'(hist_r[hp]);
        hist_a[hp] = hb_en_a;
        hist_b[hp] = hb_en_b;
        hist_r[hp] = hb_en_a_r;
        hp = (hp + 1) % 256;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                int act;
                act = observe(sb[i].kind);
                n_tests++;
                if ((sb[i].cyc < cyc) || (act != sb[i].val)) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): got %0d, expected %0d", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input int k, input int v, input string nm);
        exp_t e;
        e.cyc = cyc + d; e.kind = k; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1; col_n = 1'b1; dir_control = 4'b0000; dir_r = 4'b0000; td_dir = 3'd0;
        duty_full = 8'd200; duty_veer = 8'd100; duty_hard = 8'd60;
        duty_ninety = 8'd150; duty_ninety_fast = 8'd220; duty_full_r = 8'd0;
        step(); step();
        push_exp(0, K_HB, 0, "rst_hb");     push_exp(0, K_ST, 0, "rst_state");
        push_exp(0, K_REV, 0, "rst_rev");   push_exp(0, K_DONE, 0, "rst_done");
        push_exp(0, K_ENA, 0, "rst_en_a");  push_exp(0, K_ENB, 0, "rst_en_b");
        push_exp(0, K_REN, 0, "rst_ramp_en");
        rst = 1'b0; t_rel = cyc;
        push_exp(1, K_HB, 4'b0101, "fwd_hb");
        repeat (300) step();
        push_exp(0, K_WA, 200, "fwd_win_a"); push_exp(0, K_WB, 200, "fwd_win_b");

        dir_control = 4'b0110;
        push_exp(1, K_HB, 4'b0110, "lhard_hb");
        repeat (300) step();
        push_exp(0, K_WA, 100, "lhard_win_a"); push_exp(0, K_WB, 60, "lhard_win_b");

        dir_control = 4'b1011;
        push_exp(1, K_HB, 4'b1001, "rpivot_hb");
        repeat (300) step();
        push_exp(0, K_WA, 220, "rpivot_win_a"); push_exp(0, K_WB, 150, "rpivot_win_b");

        dir_control = 4'b0001;
        push_exp(1, K_HB, 4'b1001, "hold_hb");
        repeat (300) step();
        push_exp(0, K_WA, 220, "hold_win_a");

        // Junction left pivot, then creep while STOP is held.
        td_dir = 3'd2; dir_control = 4'b1100;
        push_exp(1, K_HB, 0, "jl_stop_hb");        push_exp(1, K_ST, 2, "jl_state");
        push_exp(2, K_HB, 4'b0110, "jl_turn_first"); push_exp(101, K_HB, 4'b0110, "jl_turn_last");
        push_exp(102, K_HB, 4'b0101, "jl_creep");  push_exp(109, K_DONE, 0, "jl_no_done");
        repeat (110) step();
        dir_control = 4'b0000;
        push_exp(1, K_DONE, 1, "jl_done");  push_exp(1, K_ST, 0, "jl_exit_state");
        push_exp(2, K_DONE, 0, "jl_done_pulse"); push_exp(2, K_HB, 4'b0101, "jl_drive_hb");
        repeat (5) step();

        // Back manoeuvre toggles orientation.
        td_dir = 3'd4; dir_control = 4'b1100;
        push_exp(1, K_ST, 2, "back_state");
        step(); dir_control = 4'b0000;
        push_exp(50, K_HB, 4'b0101, "back_last");  push_exp(50, K_REV, 0, "back_rev_pre");
        push_exp(51, K_REV, 1, "back_rev");        push_exp(51, K_DONE, 1, "back_done");
        push_exp(52, K_HB, 4'b1010, "rev_straight_hb");
        repeat (60) step();

        // Straight-through clears orientation.
        td_dir = 3'd1; dir_control = 4'b1100;
        push_exp(1, K_HB, 0, "str_stop_hb");
        step(); dir_control = 4'b0000;
        push_exp(20, K_HB, 4'b1010, "str_rev_hb"); push_exp(21, K_REV, 0, "str_rev_clr");
        push_exp(21, K_DONE, 1, "str_done");       push_exp(22, K_HB, 4'b0101, "str_exit_hb");
        repeat (30) step();

        // Collision at junction count 40, one bounce during CLEAR.
        td_dir = 3'd2; dir_control = 4'b1100;
        repeat (41) step();
        col_n = 1'b0;
        push_exp(1, K_ST, 1, "col_enter"); push_exp(3, K_ENA, 0, "col_en_a"); push_exp(3, K_ENB, 0, "col_en_b");
        repeat (4) step();
        col_n = 1'b1;
        push_exp(1, K_ST, 3, "clr_enter"); push_exp(3, K_ENA, 0, "clr_en_a");
        repeat (3) step();
        col_n = 1'b0;
        push_exp(1, K_ST, 1, "bounce_col");
        step();
        col_n = 1'b1;
        push_exp(1, K_ST, 3, "bounce_clr");   push_exp(5, K_ENB, 0, "bounce_en_b");
        push_exp(10, K_ST, 3, "clr_last");    push_exp(11, K_ST, 2, "col_resume");
        push_exp(11, K_ENA, 0, "resume_en_a");
        push_exp(71, K_HB, 4'b0110, "resume_turn_last"); push_exp(72, K_HB, 4'b0101, "resume_creep");
        repeat (75) step();
        dir_control = 4'b0000;
        push_exp(1, K_DONE, 1, "col_jnc_done");
        repeat (3) step();

        // Collision wins over a simultaneous STOP command.
        dir_control = 4'b1100; col_n = 1'b0;
        push_exp(1, K_ST, 1, "prio_col");
        step(); dir_control = 4'b0000; col_n = 1'b1;
        push_exp(1, K_ST, 3, "prio_clr"); push_exp(10, K_ST, 3, "prio_clr_last");
        push_exp(11, K_ST, 0, "prio_resume_drive");
        repeat (14) step();

        // Unknown junction code exits immediately.
        td_dir = 3'd7; dir_control = 4'b1100;
        push_exp(1, K_ST, 2, "bad_td_enter"); push_exp(2, K_ST, 0, "bad_td_exit");
        push_exp(2, K_DONE, 1, "bad_td_done");
        step(); dir_control = 4'b0000;
        repeat (4) step();

        // Reset mid-manoeuvre.
        td_dir = 3'd4; dir_control = 4'b1100;
        repeat (20) step();
        push_exp(0, K_HB, 4'b0101, "mid_hb"); push_exp(0, K_ST, 2, "mid_state");
        rst = 1'b1;
        push_exp(1, K_HB, 0, "mid_rst_hb"); push_exp(1, K_ST, 0, "mid_rst_state");
        step(); step();
        dir_control = 4'b0000; td_dir = 3'd0; rst = 1'b0; t_rel = cyc;
        push_exp(1, K_HB, 4'b0101, "post_rst_hb");

        // Slewed instance: raise 0 -> 128 while the PWM counter sits near 90.
        step();
        while (((cyc - t_rel) % 256) != 90) step();
        duty_full_r = 8'd128;
        push_exp(5, K_REN, 0, "ramp_slow_a"); push_exp(15, K_REN, 0, "ramp_slow_b");
        repeat (300) step();
        push_exp(0, K_WR, 128, "ramp_final_win");
        step();
        while (((cyc - t_rel) % 256) != 10) step();
        dir_r = 4'b1100;
        push_exp(1, K_REN, 1, "ramp_pre_stop"); push_exp(2, K_REN, 0, "ramp_stop_en");
        push_exp(6, K_REN, 0, "ramp_stop_hold");
        repeat (10) step();

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
